// File: rtl/jzjpcc_mem_types.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package jzjpcc_mem_types;

    // Records which requester owns the read that is currently in flight.
    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_FETCH,
        OWNER_DATA
    } mem_owner_t;

    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

    // Wide enough for the largest legal starvation limit (15).
    localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/jzjpcc_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
interface jzjpcc_mem_arbiter_if;

    // Fetch side
    logic        fetchReq;
    logic [29:0] fetchAddress;
    logic        fetchReady;
    logic        fetchRespValid;
    logic [31:0] fetchRespData;

    // Load/store side
    logic        dataReq;
    logic        dataWrite;
    logic [29:0] dataAddress;
    logic [3:0]  dataByteMask;
    logic [31:0] dataWriteData;
    logic        dataReady;
    logic        dataRespValid;
    logic [31:0] dataRespData;

    // Memory port
    logic        memStall;
    logic [29:0] memAddress;
    logic [3:0]  memByteMask;
    logic [31:0] memWriteData;
    logic        memReadEnable;
    logic        memWriteEnable;
    logic [31:0] memReadData;

    // Arbiter view
    modport slave (
        input  fetchReq, fetchAddress, dataReq, dataWrite, dataAddress, dataByteMask,
               dataWriteData, memStall, memReadData,
        output fetchReady, fetchRespValid, fetchRespData, dataReady, dataRespValid,
               dataRespData, memAddress, memByteMask, memWriteData, memReadEnable,
               memWriteEnable
    );

    // Requester/memory view
    modport master (
        output fetchReq, fetchAddress, dataReq, dataWrite, dataAddress, dataByteMask,
               dataWriteData, memStall, memReadData,
        input  fetchReady, fetchRespValid, fetchRespData, dataReady, dataRespValid,
               dataRespData, memAddress, memByteMask, memWriteData, memReadEnable,
               memWriteEnable
    );

endinterface

// File: rtl/jzjpcc_mem_arbiter_grant.sv
// Combinational grant decision: data wins contention unless fetch has been
// starved for STARVE_LIMIT consecutive contended data grants.
module jzjpcc_mem_arbiter_grant
    import jzjpcc_mem_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                fetchReq,
    input  logic                dataReq,
    input  logic                memStall,
    input  logic [STREAK_W-1:0] streak,
    output logic                grantFetch,
    output logic                grantData
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    // At most one grant per cycle; a stalled memory grants nobody
    always_comb begin
        grantFetch = 1'b0;
        grantData  = 1'b0;
        if (!memStall) begin
            if (fetchReq && dataReq) begin
                if (streak == LIMIT) begin
                    grantFetch = 1'b1;
                end else begin
                    grantData = 1'b1;
                end
            end else begin
                grantFetch = fetchReq;
                grantData  = dataReq;
            end
        end
    end

endmodule

// File: rtl/jzjpcc_mem_arbiter.sv
// Arbitrates the single synchronous memory port between fetch and load/store,
// drives the port from the winner and steers the next-cycle read data back.
module jzjpcc_mem_arbiter
    import jzjpcc_mem_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 n_reset,
    jzjpcc_mem_arbiter_if.slave  bus
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic                fetch_req;
    logic                data_req;
    logic                grant_fetch;
    logic                grant_data;
    logic [STREAK_W-1:0] streak_q, streak_d;
    mem_owner_t          pending_owner_q, pending_owner_d;

    logic [29:0] mem_address;
    logic [3:0]  mem_byte_mask;
    logic [31:0] mem_write_data;
    logic        mem_read_enable;
    logic        mem_write_enable;

    // Requests are masked while in reset so no ready or strobe can escape
    always_comb begin
        fetch_req = bus.fetchReq & n_reset;
        data_req  = bus.dataReq & n_reset;
    end

    jzjpcc_mem_arbiter_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .fetchReq   (fetch_req),
        .dataReq    (data_req),
        .memStall   (bus.memStall),
        .streak     (streak_q),
        .grantFetch (grant_fetch),
        .grantData  (grant_data)
    );

    // Memory port mux: driven from the winner, all-zero when nobody is granted
    always_comb begin
        mem_address      = '0;
        mem_byte_mask    = '0;
        mem_write_data   = '0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        if (grant_fetch) begin
            mem_address     = bus.fetchAddress;
            mem_byte_mask   = FULL_WORD_MASK;
            mem_read_enable = 1'b1;
        end else if (grant_data) begin
            mem_address   = bus.dataAddress;
            mem_byte_mask = bus.dataByteMask;
            if (bus.dataWrite) begin
                mem_write_data   = bus.dataWriteData;
                mem_write_enable = 1'b1;
            end else begin
                mem_read_enable = 1'b1;
            end
        end
    end

    // Next-state for starvation streak and read ownership
    always_comb begin
        streak_d = streak_q;
        if (!bus.fetchReq || grant_fetch) begin
            streak_d = '0;
        end else if (grant_data && (streak_q != LIMIT)) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        pending_owner_d = OWNER_NONE;
        if (grant_fetch) begin
            pending_owner_d = OWNER_FETCH;
        end else if (grant_data && !bus.dataWrite) begin
            pending_owner_d = OWNER_DATA;
        end
    end

    // State registers; a read in flight at reset is simply forgotten
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            streak_q        <= '0;
            pending_owner_q <= OWNER_NONE;
        end else begin
            streak_q        <= streak_d;
            pending_owner_q <= pending_owner_d;
        end
    end

    assign bus.fetchReady     = grant_fetch;
    assign bus.dataReady      = grant_data;
    assign bus.memAddress     = mem_address;
    assign bus.memByteMask    = mem_byte_mask;
    assign bus.memWriteData   = mem_write_data;
    assign bus.memReadEnable  = mem_read_enable;
    assign bus.memWriteEnable = mem_write_enable;

    // Read data is steered to the owner regardless of memStall
    assign bus.fetchRespValid = (pending_owner_q == OWNER_FETCH);
    assign bus.dataRespValid  = (pending_owner_q == OWNER_DATA);
    assign bus.fetchRespData  = (pending_owner_q == OWNER_FETCH) ? bus.memReadData : 32'h0;
    assign bus.dataRespData   = (pending_owner_q == OWNER_DATA) ? bus.memReadData : 32'h0;

endmodule
